// File: rtl/tx_pp_pkg.sv
// Shared constants for the TX ping-pong frame buffer.
package tx_pp_pkg;

  // Number of pages in the ping-pong pair
  localparam int PAGE_NUM = 2;
  // Byte address width within one page
  localparam int ADDR_W   = 8;
  // Byte width
  localparam int DATA_W   = 8;
  // Width of the successful-frame counter
  localparam int CNT_W    = 8;
  // Bits needed to select a page
  localparam int SEL_W    = $clog2(PAGE_NUM);

endpackage

// File: rtl/tx_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset; the storage array is never cleared.
import tx_pp_pkg::*;

module tx_dpram #(
  parameter int AW = ADDR_W + SEL_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Write port: store the byte at the requested address
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: one-cycle registered read, output register cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= {DW{1'b0}};
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tx_pp_ram.sv
// Two-page ping-pong frame buffer feeding the TX byte serializer.
// The CPU fills the write page and submits it; the serializer reads the
// other page and releases it with read_done (cd_err marks an abort).
import tx_pp_pkg::*;

module tx_pp_ram #(
  parameter int ADDR_W = tx_pp_pkg::ADDR_W,
  parameter int DATA_W = tx_pp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              switch_req,
  output logic              switch_err,
  output logic              has_free,
  output logic              unread,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              read_done,
  input  logic              cd_err,
  output logic              tx_done,
  output logic              tx_err,
  output logic [CNT_W-1:0]  sent_cnt
);

  logic             r_wr_sel;
  logic             r_unread;
  logic             r_switch_err;
  logic             r_tx_done;
  logic             r_tx_err;
  logic [CNT_W-1:0] r_sent_cnt;

  logic             w_release;
  logic             w_accept;
  logic             w_reject;
  logic [ADDR_W:0]  w_waddr;
  logic [ADDR_W:0]  w_raddr;

  // Release of the pending frame takes priority; a switch may reuse the page freed this cycle
  always_comb begin
    w_release = read_done & r_unread;
    w_accept  = switch_req & (~r_unread | read_done);
    w_reject  = switch_req & ~w_accept;
  end

  // CPU writes go to the page it owns; the serializer reads the other one
  assign w_waddr = {r_wr_sel, wr_addr};
  assign w_raddr = {~r_wr_sel, addr};

  tx_dpram #(
    .AW (ADDR_W + 1),
    .DW (DATA_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (wr_en),
    .i_waddr (w_waddr),
    .i_wdata (wr_data),
    .i_raddr (w_raddr),
    .o_rdata (data)
  );

  // Page ownership, frame status pulses and the sent-frame counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_sel     <= 1'b0;
      r_unread     <= 1'b0;
      r_switch_err <= 1'b0;
      r_tx_done    <= 1'b0;
      r_tx_err     <= 1'b0;
      r_sent_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_tx_done    <= w_release & ~cd_err;
      r_tx_err     <= w_release & cd_err;
      r_switch_err <= w_reject;
      if (w_release && !cd_err) begin
        r_sent_cnt <= r_sent_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        r_wr_sel <= ~r_wr_sel;
        r_unread <= 1'b1;
      end else if (w_release) begin
        r_unread <= 1'b0;
      end
    end
  end

  assign unread     = r_unread;
  assign has_free   = ~r_unread;
  assign switch_err = r_switch_err;
  assign tx_done    = r_tx_done;
  assign tx_err     = r_tx_err;
  assign sent_cnt   = r_sent_cnt;

endmodule

// File: tb/tb_tx_pp_ram.sv
// Self-checking bench for tx_pp_ram: directed vector table, counter wrap,
// then randomized traffic against a page-ownership reference model.
module tb_tx_pp_ram;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       switch_req;
  logic       switch_err;
  logic       has_free;
  logic       unread;
  logic [7:0] addr;
  logic [7:0] data;
  logic       read_done;
  logic       cd_err;
  logic       tx_done;
  logic       tx_err;
  logic [7:0] sent_cnt;

  int n_chk = 0;
  int n_err = 0;

  tx_pp_ram dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .switch_req (switch_req),
    .switch_err (switch_err),
    .has_free   (has_free),
    .unread     (unread),
    .addr       (addr),
    .data       (data),
    .read_done  (read_done),
    .cd_err     (cd_err),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .sent_cnt   (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two pages of memory, which page the CPU owns, and
  // whether the serializer's page holds a frame not yet released.
  logic [7:0] m_mem [512];
  bit         m_vld [512];
  int         m_cpu_page;
  bit         m_pending;
  int         m_frames_ok;
  bit         m_se, m_td, m_te;
  logic [7:0] m_data;
  bit         m_dv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    int  rd_idx, wr_idx;
    bit  released, accepted;
    @(posedge clk);
    rd_idx = (1 - m_cpu_page) * 256 + int'(addr);
    wr_idx = m_cpu_page * 256 + int'(wr_addr);
    if (!reset_n) begin
      m_data = 8'h00;
      m_dv   = 1'b1;
    end else begin
      m_data = m_mem[rd_idx];
      m_dv   = m_vld[rd_idx];
    end
    if (wr_en) begin
      m_mem[wr_idx] = wr_data;
      m_vld[wr_idx] = 1'b1;
    end
    if (!reset_n) begin
      m_cpu_page  = 0;
      m_pending   = 1'b0;
      m_frames_ok = 0;
      m_se = 1'b0; m_td = 1'b0; m_te = 1'b0;
    end else begin
      released = read_done && m_pending;
      accepted = switch_req && (!m_pending || read_done);
      m_td = released && !cd_err;
      m_te = released && cd_err;
      m_se = switch_req && !accepted;
      if (m_td) m_frames_ok = m_frames_ok + 1;
      if (released) m_pending = 1'b0;
      if (accepted) begin
        m_cpu_page = 1 - m_cpu_page;
        m_pending  = 1'b1;
      end
    end
    #1;
    chk("m_unread", unread, m_pending);
    chk("m_has_free", has_free, !m_pending);
    chk("m_switch_err", switch_err, m_se);
    chk("m_tx_done", tx_done, m_td);
    chk("m_tx_err", tx_err, m_te);
    chk("m_sent_cnt", sent_cnt, m_frames_ok % 256);
    if (m_dv) chk("m_data", data, m_data);
  endtask

  typedef struct {
    logic       rst_n, we;
    logic [7:0] wa, wd;
    logic       sw;
    logic [7:0] ad;
    logic       rd, cd;
    logic       u, se, td, te;
    logic [7:0] cnt;
    logic       dv;
    logic [7:0] dat;
  } vec_t;

  function automatic vec_t mk(int rst_n, int we, int wa, int wd, int sw, int ad, int rd, int cd,
                              int u, int se, int td, int te, int cnt, int dv, int dat);
    vec_t v;
    v.rst_n = 1'(rst_n); v.we = 1'(we); v.wa = 8'(wa); v.wd = 8'(wd);
    v.sw = 1'(sw); v.ad = 8'(ad); v.rd = 1'(rd); v.cd = 1'(cd);
    v.u = 1'(u); v.se = 1'(se); v.td = 1'(td); v.te = 1'(te);
    v.cnt = 8'(cnt); v.dv = 1'(dv); v.dat = 8'(dat);
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    switch_req = 1'b0; addr = 8'h00; read_done = 1'b0; cd_err = 1'b0;

    //            rst we wa  wd    sw ad rd cd   u se td te cnt dv dat
    tbl[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 8'h00);
    tbl[1]  = mk(1, 1, 0, 8'h11, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 8'h00);
    tbl[2]  = mk(1, 1, 1, 8'h22, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(1, 1, 2, 8'h33, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk(1, 0, 0, 8'h00, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 8'h00);
    tbl[5]  = mk(1, 0, 0, 8'h00, 0, 1, 0, 0,   1, 0, 0, 0, 0, 1, 8'h22);
    tbl[6]  = mk(1, 0, 0, 8'h00, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 8'h11);
    tbl[7]  = mk(1, 0, 0, 8'h00, 0, 2, 0, 0,   1, 0, 0, 0, 0, 1, 8'h33);
    tbl[8]  = mk(1, 0, 0, 8'h00, 0, 2, 1, 0,   0, 0, 1, 0, 1, 1, 8'h33);
    tbl[9]  = mk(1, 1, 1, 8'h66, 0, 2, 0, 0,   0, 0, 0, 0, 1, 1, 8'h33);
    tbl[10] = mk(1, 1, 0, 8'h44, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 8'h11);
    tbl[11] = mk(1, 0, 0, 8'h00, 1, 0, 0, 0,   1, 0, 0, 0, 1, 1, 8'h11);
    tbl[12] = mk(1, 1, 5, 8'h55, 1, 0, 1, 0,   1, 0, 1, 0, 2, 1, 8'h44);
    tbl[13] = mk(1, 0, 0, 8'h00, 0, 5, 0, 0,   1, 0, 0, 0, 2, 1, 8'h55);
    tbl[14] = mk(1, 0, 0, 8'h00, 0, 5, 1, 1,   0, 0, 0, 1, 2, 1, 8'h55);
    tbl[15] = mk(1, 0, 0, 8'h00, 0, 5, 0, 0,   0, 0, 0, 0, 2, 1, 8'h55);
    tbl[16] = mk(1, 0, 0, 8'h00, 0, 5, 0, 1,   0, 0, 0, 0, 2, 1, 8'h55);
    tbl[17] = mk(1, 0, 0, 8'h00, 0, 5, 1, 0,   0, 0, 0, 0, 2, 1, 8'h55);
    tbl[18] = mk(1, 0, 0, 8'h00, 1, 5, 0, 0,   1, 0, 0, 0, 2, 1, 8'h55);
    tbl[19] = mk(1, 0, 0, 8'h00, 0, 1, 1, 0,   0, 0, 1, 0, 3, 1, 8'h66);
    tbl[20] = mk(1, 0, 0, 8'h00, 1, 1, 0, 0,   1, 0, 0, 0, 3, 1, 8'h66);
    tbl[21] = mk(0, 0, 0, 8'h00, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 8'h00);
    tbl[22] = mk(1, 0, 0, 8'h00, 1, 1, 0, 0,   1, 0, 0, 0, 0, 1, 8'h66);
    tbl[23] = mk(1, 0, 0, 8'h00, 0, 1, 0, 0,   1, 0, 0, 0, 0, 1, 8'h22);

    // Directed vectors
    for (int i = 0; i < 24; i++) begin
      reset_n = tbl[i].rst_n; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      switch_req = tbl[i].sw; addr = tbl[i].ad; read_done = tbl[i].rd; cd_err = tbl[i].cd;
      tick();
      chk($sformatf("v%0d_unread", i), unread, tbl[i].u);
      chk($sformatf("v%0d_has_free", i), has_free, !tbl[i].u);
      chk($sformatf("v%0d_switch_err", i), switch_err, tbl[i].se);
      chk($sformatf("v%0d_tx_done", i), tx_done, tbl[i].td);
      chk($sformatf("v%0d_tx_err", i), tx_err, tbl[i].te);
      chk($sformatf("v%0d_sent_cnt", i), sent_cnt, tbl[i].cnt);
      if (tbl[i].dv) chk($sformatf("v%0d_data", i), data, tbl[i].dat);
    end

    // 256 good frames back to back: release and resubmit every cycle
    wr_en = 1'b0; reset_n = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      read_done = 1'b1; cd_err = 1'b0; switch_req = 1'b1;
      tick();
      if (k == 255) chk("wrap_cnt_255", sent_cnt, 32'd255);
      if (k == 256) chk("wrap_cnt_0", sent_cnt, 32'd0);
    end
    read_done = 1'b0; switch_req = 1'b0;
    tick();
    chk("wrap_unread_held", unread, 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = 8'($urandom_range(0, 15));
      wr_data    = 8'($urandom);
      switch_req = ($urandom_range(0, 3) == 0);
      addr       = 8'($urandom_range(0, 15));
      read_done  = ($urandom_range(0, 3) == 0);
      cd_err     = ($urandom_range(0, 2) == 0);
      tick();
    end

    reset_n = 1'b1; wr_en = 1'b0; switch_req = 1'b0; read_done = 1'b0; cd_err = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_pp_ram.md
Name: tx_pp_ram

Overview:
Two-page ping-pong frame buffer that sits upstream of the TX byte serializer.
- The CPU/register side fills one page (the write page) and submits it.
- The serializer reads the other page (the read page) by byte address, then releases it with read_done.
- The block tracks page ownership, flags a pending frame via unread, and reports completion and abort to the control center.

Parameters:
ADDR_W, 8, byte address width per page (page depth = 2**ADDR_W bytes)
DATA_W, 8, byte width

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
wr_en  in  1  CPU byte write strobe into write page
wr_addr  in  ADDR_W  CPU byte address within write page
wr_data  in  DATA_W  CPU write byte
switch_req  in  1  pulse: submit write page for transmission
switch_err  out  1  pulse: switch_req rejected (read page still pending)
has_free  out  1  other page is free; a switch_req will be accepted
unread  out  1  read page holds a submitted, unconsumed frame
addr  in  ADDR_W  serializer read address
data  out  DATA_W  byte at addr of read page, registered
read_done  in  1  pulse from serializer: read page finished (sent or aborted)
cd_err  in  1  qualifies read_done: frame aborted after retries
tx_done  out  1  pulse: frame sent OK
tx_err  out  1  pulse: frame dropped on collision error
sent_cnt  out  8  count of successful frames, wraps

Behaviour:
Reset: all synchronous to clk while reset_n=0.
- wr_sel=0, unread=0, has_free=1, switch_err=0, tx_done=0, tx_err=0, sent_cnt=0, data=0.
- RAM contents are not cleared.

Page state:
- Page wr_sel is owned by the CPU; page !wr_sel is the read page.
- Read page is PENDING when unread=1, otherwise FREE.
- has_free = !unread, combinational.

Writes:
- wr_en=1 writes wr_data to RAM[{wr_sel, wr_addr}] at the clock edge.
- Writes are never blocked.

Reads:
- data <= RAM[{!wr_sel, addr}] every cycle; 1-cycle latency.
- Read data is valid regardless of unread.

Switch (evaluated each cycle, priority order):
1. read_done && unread:
   - unread is cleared.
   - If cd_err=1: tx_err pulses for 1 cycle.
   - Else: tx_done pulses for 1 cycle and sent_cnt increments (255 -> 0).
2. switch_req:
   - Accepted if the page is free after step 1, i.e. (!unread || read_done) in the same cycle.
   - On accept, the next cycle has wr_sel flipped and unread=1.
   - On reject: switch_err pulses for 1 cycle; wr_sel and unread unchanged.
   - A write in the same cycle as an accepted switch lands in the old write page (becomes part of the submitted frame).

Other rules:
- read_done with unread=0: ignored, no pulses.
- cd_err without read_done: ignored.
- Outputs tx_done, tx_err, switch_err are single-cycle pulses. No other outputs pulse.
- Reset asserted mid-frame: unread drops to 0 next edge. The serializer's own reset covers its side. No pulses are emitted for the aborted frame.

Decomposition:
Shared package tx_pp_pkg:
- constants PAGE_NUM=2, ADDR_W, DATA_W.
Sub-module tx_dpram:
- simple dual-port RAM, (ADDR_W+1)-bit address, one write port, one registered read port.
- Inferable as block RAM.
Control logic (wr_sel, unread, pulses, counter) stays in tx_pp_ram.

Test Plan:
- Write 0x11,0x22,0x33 to addr 0..2, switch_req -> next cycle unread=1, has_free=0. Then addr=1 -> data=0x22 one cycle later.
- With unread=1, pulse switch_req -> switch_err=1 for 1 cycle; wr_sel/unread unchanged; RAM write page untouched.
- read_done=1, cd_err=0 with unread=1 -> tx_done 1 cycle, sent_cnt 0->1, unread=0, has_free=1.
- read_done and switch_req in the same cycle, unread=1 -> no switch_err, no tx_err; tx_done=1; unread stays 1; wr_sel flips.
- read_done with cd_err=1 -> tx_err pulse, sent_cnt unchanged. Then 256 good frames -> sent_cnt wraps to 0.
- reset_n=0 for 1 cycle while unread=1 -> unread=0, wr_sel=0, sent_cnt=0, no pulses. A subsequent switch_req is accepted.
